// File: rtl/bpu_ghr_ckpt_pkg.sv
// Shared defaults and types for the speculative global-history register and its
// checkpoint queue.
package bpu_ghr_ckpt_pkg;

   localparam int BPU_GHR_BITS   = 32;
   localparam int BPU_FETCH_BR   = 2;
   localparam int BPU_CKPT_DEPTH = 8;

   typedef logic [$clog2(BPU_CKPT_DEPTH)-1:0] ghr_ckpt_id_t;
   typedef logic [$clog2(BPU_FETCH_BR+1)-1:0] ghr_cnt_t;
   typedef logic [BPU_GHR_BITS-1:0]           ghr_vec_t;

   // Source selected for the next speculative history value.
   typedef enum logic [1:0] {
      GHR_HOLD  = 2'd0,
      GHR_SPEC  = 2'd1,
      GHR_REDIR = 2'd2,
      GHR_FLUSH = 2'd3
   } ghr_src_e;

endpackage

// File: rtl/bpu_ghr_ckpt_shift.sv
// Combinational history shift: inserts cnt_i outcomes below hist_i, with the
// oldest outcome (taken_i[0]) landing highest and taken_i[cnt_i-1] at bit 0.
module bpu_ghr_shift #(
   parameter  int GHR_BITS = 32,
   parameter  int FETCH_BR = 2,
   localparam int CW       = $clog2(FETCH_BR+1)
) (
   input  logic [GHR_BITS-1:0] hist_i,
   input  logic [CW-1:0]       cnt_i,
   input  logic [FETCH_BR-1:0] taken_i,
   output logic [GHR_BITS-1:0] hist_o
);

   always_comb begin
      hist_o = hist_i;
      for (int n = 1; n <= FETCH_BR; n++) begin
         if (cnt_i == CW'(n)) begin
            hist_o = hist_i << n;
            for (int k = 0; k < n; k++) hist_o[n-1-k] = taken_i[k];
         end
      end
   end

endmodule

// File: rtl/bpu_ghr_ckpt.sv
// Speculative GHR with an in-order checkpoint queue; commit advances the
// architectural history, redirect restores from a checkpoint, flush resyncs.
module bpu_ghr_ckpt
   import bpu_ghr_ckpt_pkg::*;
#(
   parameter  int GHR_BITS   = BPU_GHR_BITS,
   parameter  int FETCH_BR   = BPU_FETCH_BR,
   parameter  int CKPT_DEPTH = BPU_CKPT_DEPTH,
   localparam int IDW        = $clog2(CKPT_DEPTH),
   localparam int CW         = $clog2(FETCH_BR+1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                spec_valid_i,
   output logic                spec_ready_o,
   input  logic [CW-1:0]       spec_cnt_i,
   input  logic [FETCH_BR-1:0] spec_taken_i,
   output logic [IDW-1:0]      ckpt_id_o,
   input  logic                commit_valid_i,
   input  logic [CW-1:0]       commit_cnt_i,
   input  logic [FETCH_BR-1:0] commit_taken_i,
   input  logic                redirect_valid_i,
   input  logic [IDW-1:0]      redirect_id_i,
   input  logic [CW-1:0]       redirect_cnt_i,
   input  logic [FETCH_BR-1:0] redirect_taken_i,
   input  logic                flush_i,
   output logic [GHR_BITS-1:0] ghr_o,
   output logic [GHR_BITS-1:0] arch_ghr_o,
   output logic [IDW:0]        count_o
);

   logic [GHR_BITS-1:0] ghr_q, ghr_d, arch_q, arch_d;
   logic [GHR_BITS-1:0] ckpt_q [CKPT_DEPTH];
   logic [IDW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [IDW:0]        count_q, count_d;

   logic [GHR_BITS-1:0] spec_hist, commit_hist, redir_hist;
   logic                commit_en, push;
   logic [IDW:0]        commit_dec;
   logic [IDW-1:0]      redir_off;
   ghr_src_e            src;

   assign spec_ready_o = (count_q != (IDW+1)'(CKPT_DEPTH));
   assign commit_en    = commit_valid_i && (count_q != '0);
   assign commit_dec   = {{IDW{1'b0}}, commit_en};
   assign push         = spec_valid_i && spec_ready_o && !redirect_valid_i && !flush_i;
   assign redir_off    = redirect_id_i - head_q;

   bpu_ghr_shift #(.GHR_BITS(GHR_BITS), .FETCH_BR(FETCH_BR)) u_shift_spec (
      .hist_i(ghr_q), .cnt_i(spec_cnt_i), .taken_i(spec_taken_i), .hist_o(spec_hist));

   bpu_ghr_shift #(.GHR_BITS(GHR_BITS), .FETCH_BR(FETCH_BR)) u_shift_commit (
      .hist_i(arch_q), .cnt_i(commit_cnt_i), .taken_i(commit_taken_i), .hist_o(commit_hist));

   bpu_ghr_shift #(.GHR_BITS(GHR_BITS), .FETCH_BR(FETCH_BR)) u_shift_redir (
      .hist_i(ckpt_q[redirect_id_i]), .cnt_i(redirect_cnt_i), .taken_i(redirect_taken_i),
      .hist_o(redir_hist));

   always_comb begin
      src = GHR_HOLD;
      if (flush_i)               src = GHR_FLUSH;
      else if (redirect_valid_i) src = GHR_REDIR;
      else if (push)             src = GHR_SPEC;
   end

   always_comb begin
      arch_d  = commit_en ? commit_hist : arch_q;
      ghr_d   = ghr_q;
      head_d  = head_q + IDW'(commit_en);
      tail_d  = tail_q;
      count_d = count_q - commit_dec;
      case (src)
         GHR_FLUSH: begin
            // Flush resyncs to the history including this cycle's commit.
            ghr_d   = arch_d;
            head_d  = tail_q;
            count_d = '0;
         end
         GHR_REDIR: begin
            ghr_d   = redir_hist;
            tail_d  = redirect_id_i + IDW'(1);
            count_d = {1'b0, redir_off} + (IDW+1)'(1) - commit_dec;
         end
         GHR_SPEC: begin
            ghr_d   = spec_hist;
            tail_d  = tail_q + IDW'(1);
            count_d = count_q + (IDW+1)'(1) - commit_dec;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ghr_q   <= '0;
         arch_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         ghr_q   <= ghr_d;
         arch_q  <= arch_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Snapshot is the pre-shift history; entries need no reset since liveness
   // is tracked by head/count alone.
   always_ff @(posedge clk_i) begin
      if (rst_ni && push) ckpt_q[tail_q] <= ghr_q;
   end

   assign ghr_o      = ghr_q;
   assign arch_ghr_o = arch_q;
   assign ckpt_id_o  = tail_q;
   assign count_o    = count_q;

   a_spec_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
      spec_valid_i |-> spec_cnt_i <= CW'(FETCH_BR)) else $error("spec_cnt_i out of range");
   a_commit_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
      commit_valid_i |-> commit_cnt_i <= CW'(FETCH_BR)) else $error("commit_cnt_i out of range");
   a_redir_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
      redirect_valid_i |-> redirect_cnt_i <= CW'(FETCH_BR)) else $error("redirect_cnt_i out of range");
   a_commit_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      commit_valid_i |-> count_q != '0) else $error("commit with empty queue");
   a_redir_live: assert property (@(posedge clk_i) disable iff (!rst_ni)
      redirect_valid_i |-> {1'b0, redir_off} < count_q) else $error("redirect to dead checkpoint");
   a_redir_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (redirect_valid_i && commit_valid_i) |-> redirect_id_i != head_q)
      else $error("redirect to head during commit");

endmodule

// File: tb/tb_bpu_ghr_ckpt.sv
// Scoreboard bench for bpu_ghr_ckpt at GHR_BITS=8, FETCH_BR=2, CKPT_DEPTH=4.
module tb_bpu_ghr_ckpt;

   localparam int GB = 8, FB = 2, CD = 4;

   logic       clk = 0, rst_n;
   logic       s_v, c_v, r_v, fl;
   logic [1:0] s_c, s_t, c_c, c_t, r_c, r_t, r_id;
   logic       rdy;
   logic [1:0] id;
   logic [7:0] ghr, arch;
   logic [2:0] cnt;

   int n_tests = 0, n_fail = 0;

   typedef struct {
      logic [7:0] ghr;
      logic [7:0] arch;
      logic [2:0] cnt;
      logic       rdy;
      logic [1:0] id;
   } exp_t;
   exp_t sbq[$];

   logic [7:0] m_ckpt [CD];
   logic [7:0] m_ghr, m_arch;
   logic [1:0] m_head, m_tail;
   int         m_cnt;

   always #5 clk = ~clk;

   bpu_ghr_ckpt #(.GHR_BITS(GB), .FETCH_BR(FB), .CKPT_DEPTH(CD)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .spec_valid_i(s_v), .spec_ready_o(rdy), .spec_cnt_i(s_c), .spec_taken_i(s_t),
      .ckpt_id_o(id),
      .commit_valid_i(c_v), .commit_cnt_i(c_c), .commit_taken_i(c_t),
      .redirect_valid_i(r_v), .redirect_id_i(r_id), .redirect_cnt_i(r_c),
      .redirect_taken_i(r_t), .flush_i(fl),
      .ghr_o(ghr), .arch_ghr_o(arch), .count_o(cnt));

   task automatic chk(string tag, int got, int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Outcomes enter one at a time, oldest first.
   function automatic logic [7:0] msh(logic [7:0] h, int n, logic [1:0] t);
      for (int i = 0; i < n; i++) h = {h[6:0], t[i]};
      return h;
   endfunction

   task automatic model();
      bit         com;
      logic [7:0] arch_n;
      if (!rst_n) begin
         m_ghr = 0; m_arch = 0; m_head = 0; m_tail = 0; m_cnt = 0;
      end else begin
         com    = c_v && (m_cnt != 0);
         arch_n = com ? msh(m_arch, int'(c_c), c_t) : m_arch;
         if (fl) begin
            m_ghr = arch_n; m_head = m_tail; m_cnt = 0;
         end else if (r_v) begin
            m_ghr  = msh(m_ckpt[r_id], int'(r_c), r_t);
            m_cnt  = int'(2'(r_id - m_head)) + 1 - int'(com);
            m_tail = r_id + 2'd1;
            m_head = m_head + 2'(com);
         end else if (s_v && m_cnt != CD) begin
            m_ckpt[m_tail] = m_ghr;
            m_ghr  = msh(m_ghr, int'(s_c), s_t);
            m_tail = m_tail + 2'd1;
            m_cnt  = m_cnt + 1 - int'(com);
            m_head = m_head + 2'(com);
         end else begin
            m_cnt  = m_cnt - int'(com);
            m_head = m_head + 2'(com);
         end
         m_arch = arch_n;
      end
   endtask

   task automatic step(string tag);
      exp_t e;
      model();
      sbq.push_back('{ghr: m_ghr, arch: m_arch, cnt: 3'(m_cnt), rdy: (m_cnt != CD), id: m_tail});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk({tag, ".ghr"},   int'(ghr),  int'(e.ghr));
      chk({tag, ".arch"},  int'(arch), int'(e.arch));
      chk({tag, ".count"}, int'(cnt),  int'(e.cnt));
      chk({tag, ".ready"}, int'(rdy),  int'(e.rdy));
      chk({tag, ".id"},    int'(id),   int'(e.id));
      s_v = 0; c_v = 0; r_v = 0; fl = 0;
   endtask

   task automatic spec(logic [1:0] c, logic [1:0] t);
      s_v = 1; s_c = c; s_t = t;
   endtask
   task automatic com(logic [1:0] c, logic [1:0] t);
      c_v = 1; c_c = c; c_t = t;
   endtask
   task automatic redir(logic [1:0] i, logic [1:0] c, logic [1:0] t);
      r_v = 1; r_id = i; r_c = c; r_t = t;
   endtask
   task automatic do_reset();
      rst_n = 0; step("reset"); rst_n = 1;
   endtask

   initial begin
      s_v = 0; c_v = 0; r_v = 0; fl = 0;
      s_c = 0; s_t = 0; c_c = 0; c_t = 0; r_c = 0; r_t = 0; r_id = 0;
      do_reset();
      chk("reset.ghr_abs", int'(ghr), 0);
      chk("reset.ready_abs", int'(rdy), 1);

      spec(2'd2, 2'b01); step("push0");
      chk("push0.ghr_abs", int'(ghr), 'h02);
      spec(2'd1, 2'b01); step("push1");
      chk("push1.ghr_abs", int'(ghr), 'h05);
      chk("push1.count_abs", int'(cnt), 2);

      redir(2'd0, 2'd1, 2'b00); step("redir0");
      chk("redir0.ghr_abs", int'(ghr), 'h00);
      chk("redir0.count_abs", int'(cnt), 1);
      chk("redir0.id_abs", int'(id), 1);

      for (int i = 0; i < 3; i++) begin spec(2'd1, 2'(i)); step("fill"); end
      chk("full.ready_abs", int'(rdy), 0);
      spec(2'd2, 2'b11); step("push_full");
      chk("push_full.count_abs", int'(cnt), 4);
      com(2'd1, 2'b01); step("commit_full");
      chk("commit_full.ready_abs", int'(rdy), 1);
      spec(2'd1, 2'b01); step("push_wrap");
      chk("push_wrap.id_abs", int'(id), 1);

      do_reset();
      spec(2'd2, 2'b11); step("p_a");
      spec(2'd2, 2'b11); step("p_b");
      com(2'd2, 2'b11); step("c_a");
      com(2'd2, 2'b11); step("c_b");
      chk("c_b.arch_abs", int'(arch), 'h0F);
      fl = 1; step("flush");
      chk("flush.ghr_abs", int'(ghr), 'h0F);
      chk("flush.count_abs", int'(cnt), 0);

      spec(2'd1, 2'b01); step("p_c");
      spec(2'd2, 2'b10); step("p_d");
      spec(2'd1, 2'b00); step("p_e");
      redir(m_head + 2'd1, 2'd2, 2'b11); spec(2'd2, 2'b01); step("redir_spec");
      spec(2'd1, 2'b01); step("p_f");
      redir(m_head + 2'd2, 2'd1, 2'b01); com(2'd1, 2'b01); step("redir_commit");
      com(2'd2, 2'b01); fl = 1; redir(m_head + 2'd1, 2'd1, 2'b01); step("flush_commit");

      spec(2'd2, 2'b10); step("p_g");
      spec(2'd2, 2'b01); step("p_h");
      spec(2'd0, 2'b11); step("p_i");
      chk("pre_rst.count_abs", int'(cnt), 3);
      spec(2'd1, 2'b01); do_reset();
      chk("mid_rst.count_abs", int'(cnt), 0);
      chk("mid_rst.ghr_abs", int'(ghr), 0);

      for (int i = 0; i < 400; i++) begin
         int off;
         s_v = 1'($urandom); s_c = 2'($urandom_range(0, 2)); s_t = 2'($urandom);
         c_v = (m_cnt != 0) && ($urandom % 3 == 0);
         c_c = 2'($urandom_range(0, 2)); c_t = 2'($urandom);
         r_v = (m_cnt != 0) && ($urandom % 6 == 0);
         r_c = 2'($urandom_range(0, 2)); r_t = 2'($urandom); r_id = m_head;
         if (r_v) begin
            if (c_v && m_cnt == 1) c_v = 0;
            off  = c_v ? int'($urandom_range(1, m_cnt - 1)) : int'($urandom_range(0, m_cnt - 1));
            r_id = m_head + 2'(off);
         end
         fl = ($urandom % 25 == 0);
         if ($urandom % 97 == 0) rst_n = 0;
         step("rand");
         rst_n = 1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
